// File: rtl/spi_pkg.sv
// Shared definitions for the SPI slave responder.
// Contents:
//   spi_state_e      - transaction FSM states (IDLE, CMD, WR, RD)
//   CMD_RD_BIT       - command-byte bit that selects read (1) or write (0)
//   sel_sample_edge  - picks the sampling SCK edge from CPHA
//   sel_shift_edge   - picks the opposite (shifting) SCK edge
//   tx_first_bit     - bit of a byte that goes out first for a given bit order
//   tx_shift_out     - drops the bit just sent
//   rx_shift_in      - appends a received bit for a given bit order
package spi_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CMD  = 2'd1,
    ST_WR   = 2'd2,
    ST_RD   = 2'd3
  } spi_state_e;

  localparam int CMD_RD_BIT = 7;

  function automatic logic sel_sample_edge(input logic cpha, input logic lead,
                                           input logic trail);
    return cpha ? trail : lead;
  endfunction

  function automatic logic sel_shift_edge(input logic cpha, input logic lead,
                                          input logic trail);
    return cpha ? lead : trail;
  endfunction

  function automatic logic tx_first_bit(input logic [7:0] b, input logic lsbfe);
    return lsbfe ? b[0] : b[7];
  endfunction

  function automatic logic [7:0] tx_shift_out(input logic [7:0] b, input logic lsbfe);
    return lsbfe ? {1'b0, b[7:1]} : {b[6:0], 1'b0};
  endfunction

  function automatic logic [7:0] rx_shift_in(input logic [7:0] b, input logic lsbfe,
                                             input logic bit_in);
    return lsbfe ? {bit_in, b[7:1]} : {b[6:0], bit_in};
  endfunction

endpackage

// File: rtl/spi_resp_sync.sv
// Input conditioning for the SPI slave responder.
// Brings SCK, SS and MOSI into the clk domain through SYNC_STG flops and
// derives single-cycle edge strobes from the synchronized levels.
// Ports:
//   clk, rst    system clock, asynchronous active-high reset
//   sck_i       raw serial clock
//   ss_i        raw slave select (active low)
//   mosi_i      raw serial data in
//   cpol_i      clock idle level, selects which SCK edge is "leading"
//   sck_lead    1-cycle strobe: SCK left its idle level
//   sck_trail   1-cycle strobe: SCK returned to its idle level
//   ss_fall     1-cycle strobe: SS went low
//   ss_rise     1-cycle strobe: SS went high
//   mosi_s      synchronized MOSI, aligned with the SCK edge strobes
module spi_resp_sync #(
  parameter int SYNC_STG = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic sck_i,
  input  logic ss_i,
  input  logic mosi_i,
  input  logic cpol_i,
  output logic sck_lead,
  output logic sck_trail,
  output logic ss_fall,
  output logic ss_rise,
  output logic mosi_s
);

  logic [SYNC_STG-1:0] sck_sync_q;
  logic [SYNC_STG-1:0] ss_sync_q;
  logic [SYNC_STG-1:0] mosi_sync_q;
  logic                sck_prev_q;
  logic                ss_prev_q;
  logic                sck_s;
  logic                ss_s;
  logic                sck_rise;
  logic                sck_fall;

  // SS chain resets to the deselected level so leaving reset never looks
  // like the start of a transaction.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples the
  // pre-edge values; blocking here would collapse the synchronizer chain.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sck_sync_q  <= '0;
      ss_sync_q   <= '1;
      mosi_sync_q <= '0;
      sck_prev_q  <= 1'b0;
      ss_prev_q   <= 1'b1;
    end else begin
      sck_sync_q  <= {sck_sync_q[SYNC_STG-2:0], sck_i};
      ss_sync_q   <= {ss_sync_q[SYNC_STG-2:0], ss_i};
      mosi_sync_q <= {mosi_sync_q[SYNC_STG-2:0], mosi_i};
      sck_prev_q  <= sck_s;
      ss_prev_q   <= ss_s;
    end
  end

  assign sck_s  = sck_sync_q[SYNC_STG-1];
  assign ss_s   = ss_sync_q[SYNC_STG-1];
  assign mosi_s = mosi_sync_q[SYNC_STG-1];

  assign sck_rise  = sck_s & ~sck_prev_q;
  assign sck_fall  = ~sck_s & sck_prev_q;
  assign sck_lead  = cpol_i ? sck_fall : sck_rise;
  assign sck_trail = cpol_i ? sck_rise : sck_fall;
  assign ss_fall   = ~ss_s & ss_prev_q;
  assign ss_rise   = ss_s & ~ss_prev_q;

endmodule

// File: rtl/spi_slave_responder.sv
// SPI slave endpoint serving a byte-wide register file.
// The first byte of a transaction is a command (bit7: 1=read, 0=write;
// low ADDR_W bits: start address); following bytes are written to, or read
// from, consecutive addresses with wrap-around. The host reads the register
// file in parallel through host_addr/host_rdata.
// Ports:
//   clk, rst          system clock, asynchronous active-high reset
//   SCK, SS, MOSI     serial inputs from the master (SS active low)
//   MISO, MISO_oe     serial output and its enable (0 while not selected)
//   CPOL, CPHA, LSBFE mode pins, captured when SS falls
//   host_addr         host read address
//   host_rdata        reg[host_addr], combinational
//   wr_pulse, wr_addr 1-cycle strobe and address per byte written over SPI
//   busy              transaction in progress
module spi_slave_responder
  import spi_pkg::*;
#(
  parameter int         ADDR_W    = 4,
  parameter int         SYNC_STG  = 2,
  parameter logic [7:0] IDLE_BYTE = 8'h00
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              SCK,
  input  logic              SS,
  input  logic              MOSI,
  output logic              MISO,
  output logic              MISO_oe,
  input  logic              CPOL,
  input  logic              CPHA,
  input  logic              LSBFE,
  input  logic [ADDR_W-1:0] host_addr,
  output logic [7:0]        host_rdata,
  output logic              wr_pulse,
  output logic [ADDR_W-1:0] wr_addr,
  output logic              busy
);

  localparam int                DEPTH    = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] ADDR_ONE = 1;

  spi_state_e        state_q, state_d;
  logic [2:0]        bit_cnt_q, bit_cnt_d;
  logic [7:0]        rx_q, rx_d;
  logic [7:0]        tx_q, tx_d;
  logic              miso_q, miso_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              wr_pulse_q, wr_pulse_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic              cpol_q, cpha_q, lsbfe_q;
  logic [7:0]        mem_q [DEPTH];

  logic              sck_lead, sck_trail, ss_fall, ss_rise, mosi_s;
  logic              sample_edge, shift_edge;
  logic [7:0]        rx_next;
  logic [ADDR_W-1:0] cmd_addr;
  logic              mem_we;

  spi_resp_sync #(.SYNC_STG(SYNC_STG)) u_sync (
    .clk       (clk),
    .rst       (rst),
    .sck_i     (SCK),
    .ss_i      (SS),
    .mosi_i    (MOSI),
    .cpol_i    (cpol_q),
    .sck_lead  (sck_lead),
    .sck_trail (sck_trail),
    .ss_fall   (ss_fall),
    .ss_rise   (ss_rise),
    .mosi_s    (mosi_s)
  );

  assign sample_edge = sel_sample_edge(cpha_q, sck_lead, sck_trail);
  assign shift_edge  = sel_shift_edge(cpha_q, sck_lead, sck_trail);
  assign rx_next     = rx_shift_in(rx_q, lsbfe_q, mosi_s);
  assign cmd_addr    = rx_next[ADDR_W-1:0];

  // Mode pins track their inputs only while idle, so the values in force at
  // SS fall stay frozen for the whole transaction.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cpol_q  <= 1'b0;
      cpha_q  <= 1'b0;
      lsbfe_q <= 1'b0;
    end else if (state_q == ST_IDLE) begin
      cpol_q  <= CPOL;
      cpha_q  <= CPHA;
      lsbfe_q <= LSBFE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      bit_cnt_q  <= '0;
      rx_q       <= '0;
      tx_q       <= '0;
      miso_q     <= 1'b0;
      addr_q     <= '0;
      wr_pulse_q <= 1'b0;
      wr_addr_q  <= '0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      rx_q       <= rx_d;
      tx_q       <= tx_d;
      miso_q     <= miso_d;
      addr_q     <= addr_d;
      wr_pulse_q <= wr_pulse_d;
      wr_addr_q  <= wr_addr_d;
    end
  end

  // miso_q holds the bit currently on the wire and tx_q the bits still to
  // go. Every byte completion reloads tx_q with a full byte, so the next
  // shift edge presents that byte's first bit in either CPHA mode.
  // NOTE: every signal gets a default at the top of always_comb; a path that
  // leaves one unassigned would infer a latch.
  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    rx_d       = rx_q;
    tx_d       = tx_q;
    miso_d     = miso_q;
    addr_d     = addr_q;
    wr_pulse_d = 1'b0;
    wr_addr_d  = wr_addr_q;
    mem_we     = 1'b0;

    if (ss_rise) begin
      // Deselect mid-byte drops the partial byte without any write.
      state_d   = ST_IDLE;
      bit_cnt_d = '0;
      rx_d      = '0;
      miso_d    = 1'b0;
    end else if (state_q == ST_IDLE) begin
      if (ss_fall) begin
        state_d   = ST_CMD;
        bit_cnt_d = '0;
        rx_d      = '0;
        if (CPHA) begin
          // First bit is driven by the first (leading) edge.
          tx_d   = IDLE_BYTE;
          miso_d = 1'b0;
        end else begin
          // First bit must be on MISO before the first SCK edge.
          tx_d   = tx_shift_out(IDLE_BYTE, LSBFE);
          miso_d = tx_first_bit(IDLE_BYTE, LSBFE);
        end
      end
    end else if (sample_edge) begin
      rx_d      = rx_next;
      bit_cnt_d = bit_cnt_q + 3'd1;
      if (bit_cnt_q == 3'd7) begin
        tx_d = IDLE_BYTE;
        case (state_q)
          ST_CMD: begin
            if (rx_next[CMD_RD_BIT]) begin
              state_d = ST_RD;
              tx_d    = mem_q[cmd_addr];
              addr_d  = cmd_addr + ADDR_ONE;
            end else begin
              state_d = ST_WR;
              addr_d  = cmd_addr;
            end
          end
          ST_WR: begin
            mem_we     = 1'b1;
            wr_pulse_d = 1'b1;
            wr_addr_d  = addr_q;
            addr_d     = addr_q + ADDR_ONE;
          end
          ST_RD: begin
            tx_d   = mem_q[addr_q];
            addr_d = addr_q + ADDR_ONE;
          end
          default: state_d = ST_IDLE;
        endcase
      end
    end else if (shift_edge) begin
      miso_d = tx_first_bit(tx_q, lsbfe_q);
      tx_d   = tx_shift_out(tx_q, lsbfe_q);
    end
  end

  // NOTE: the register file is architecturally visible and must read 0 after
  // reset, so it is reset here rather than left as an uninitialized RAM.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (mem_we) begin
      mem_q[addr_q] <= rx_next;
    end
  end

  assign host_rdata = mem_q[host_addr];
  assign busy       = (state_q != ST_IDLE);
  assign MISO_oe    = busy;
  assign MISO       = busy & miso_q;
  assign wr_pulse   = wr_pulse_q;
  assign wr_addr    = wr_addr_q;

endmodule
